// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: wide W = N*K bit adder built by time-multiplexing one
// N-bit ripple-carry adder over K chunks, least significant chunk first.
// Also contains RCA_parametrizable, the shared N-bit ripple-carry adder.

module RCA_parametrizable #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] S,
   output logic         Cout
);

   logic [N:0] c;

   assign c[0] = Cin;

   // One full adder per bit, carry rippling upward
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign Cout = c[N];

endmodule

module rca_word_sequencer #(
   parameter int unsigned N = 4,
   parameter int unsigned K = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N*K-1:0] A,
   input  logic [N*K-1:0] B,
   input  logic           Cin,
   output logic [N*K-1:0] Sum,
   output logic           Cout,
   output logic           busy,
   output logic           done
);

   localparam int unsigned W  = N * K;
   localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           carry_q;
   logic [W-1:0]   part_q;
   logic [IW-1:0]  idx_q;

   logic [BW-1:0]  base_c;
   logic           last_c;
   logic [N-1:0]   rca_a_c;
   logic [N-1:0]   rca_b_c;
   logic [N-1:0]   rca_s_c;
   logic           rca_co_c;
   logic [W-1:0]   sum_next_c;

   // Bit offset of the chunk currently being processed
   assign base_c  = BW'(idx_q * N);
   assign last_c  = (idx_q == IW'(K - 1));
   assign rca_a_c = a_q[base_c +: N];
   assign rca_b_c = b_q[base_c +: N];

   RCA_parametrizable #(.N(N)) u_rca (
      .A    (rca_a_c),
      .B    (rca_b_c),
      .Cin  (carry_q),
      .S    (rca_s_c),
      .Cout (rca_co_c)
   );

   // Partial result with the current chunk merged in (also the final word on the last chunk)
   always_comb begin
      sum_next_c                = part_q;
      sum_next_c[base_c +: N]   = rca_s_c;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)  state_d = S_RUN;
         S_RUN:   if (last_c) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand capture, per-chunk accumulation, result and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         part_q  <= '0;
         idx_q   <= '0;
         Sum     <= '0;
         Cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= (state_d == S_RUN);
         done <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= Cin;
                  idx_q   <= '0;
               end
            end
            S_RUN: begin
               part_q  <= sum_next_c;
               carry_q <= rca_co_c;
               idx_q   <= idx_q + IW'(1);
               if (last_c) begin
                  Sum  <= sum_next_c;
                  Cout <= rca_co_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Testbench for rca_word_sequencer (N=4, K=4): scoreboard of A+B+Cin results
// checked by an independent monitor on every done pulse.

module tb_rca_word_sequencer;

   localparam int unsigned N = 4;
   localparam int unsigned K = 4;
   localparam int unsigned W = N * K;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;

   int checks;
   int errors;

   logic [W:0] exp_q[$];
   logic [W:0] held;

   rca_word_sequencer #(.N(N), .K(K)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a),
      .B     (b),
      .Cin   (cin),
      .Sum   (sum),
      .Cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse pops the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[W-1:0]));
            check("cout", 32'(cout), 32'(e[W]));
         end
      end
   end

   // Issue one op; optionally disturb inputs mid-run; checks latency, busy length and held result
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input bit disturb);
      int m;
      int busy_cnt;
      bit seen;
      logic [W:0] e;
      @(negedge clk);
      a = av; b = bv; cin = cv; start = 1'b1;
      e = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      m = 0; busy_cnt = 0; seen = 0;
      while (m < 3 * K + 4) begin
         if (busy) busy_cnt++;
         if (done) begin seen = 1; break; end
         if (busy) check("hold_sum", 32'({cout, sum}), 32'(held));
         if (disturb && m == 1) begin
            a = 16'h0F0F; b = W'($urandom); cin = 1'b1; start = 1'b1;
         end else begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b0;
         end
         @(negedge clk);
         m++;
      end
      start = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done after %0d cycles", K);
      end else begin
         check("latency", 32'(m), 32'(K));
         check("busy_len", 32'(busy_cnt), 32'(K));
         held = e;
         @(negedge clk);
         check("done_single", 32'(done), 32'd0);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      held = '0;
      repeat (2) @(negedge clk);
      check("rst_sum", 32'(sum), 32'h0);
      check("rst_cout", 32'(cout), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_nostart", 32'(busy), 32'h0);

      run_op(16'h0001, 16'h0002, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'hA5A5, 16'h5A5A, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
      run_op(16'h1234, 16'h1111, 1'b0, 1);

      // Reset two cycles after start aborts the op and clears the result
      @(negedge clk);
      a = 16'h4444; b = 16'h3333; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("abort_sum", 32'(sum), 32'h0);
      check("abort_cout", 32'(cout), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      held = '0;
      repeat (K + 2) @(negedge clk);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);

      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (K + 4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_word_sequencer.md
# rca_word_sequencer

Multi-cycle sequencer that computes a wide `W = N*K`-bit addition by time-multiplexing a single `N`-bit `RCA_parametrizable` instance over `K` chunks, least significant chunk first. It latches the operands on `start`, sequences one chunk per clock with the carry registered between chunks, and presents the registered result with a one-cycle `done` pulse. It sits between any wide-operand requester and the team's parametrizable ripple-carry adder, trading latency for area.

## Interface
Parameters:
- `N`, 4, chunk width; passed to the internal `RCA_parametrizable #(.N(N))`.
- `K`, 4, number of chunks; `K >= 1`. Operand width is `W = N*K`, derived locally and not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  W  operand A; sampled on the accepted `start` edge.
- `B`  in  W  operand B; sampled on the accepted `start` edge.
- `Cin`  in  1  carry-in to chunk 0; sampled on the accepted `start` edge.
- `Sum`  out  W  registered result.
- `Cout`  out  1  registered carry-out of chunk K-1.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.

## Operation
- Exactly one `RCA_parametrizable` instance. No other adder logic in the block.
- Internal registers: `a_q`, `b_q` (W), `carry_q` (1), `part_q` (W), `idx_q` (`$clog2(K)` bits, minimum 1).
- FSM states: IDLE, RUN, DONE.
- IDLE: if `start=1`, load `a_q<=A`, `b_q<=B`, `carry_q<=Cin`, `idx_q<=0`, and go to RUN. Otherwise stay.
- RUN:
  - RCA inputs are `a_q[idx_q*N +: N]`, `b_q[idx_q*N +: N]`, and `carry_q`.
  - Each edge writes the RCA sum into `part_q[idx_q*N +: N]`, sets `carry_q<=RCA Cout`, and increments `idx_q`.
  - On the edge that processes chunk K-1, load `Sum<={RCA sum, part_q[(K-1)*N-1:0]}` (for `K=1`, just the RCA sum), load `Cout<=RCA Cout`, and go to DONE.
- DONE: `done=1` for this single cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored and never queued. Changes on `A`/`B`/`Cin` after acceptance have no effect.
- `Sum`/`Cout` change only on the edge entering DONE. They hold the previous result through later IDLE and RUN phases until the next completion.
- Arithmetic is unsigned modulo 2^W. `Cout` is bit W of `A+B+Cin`. Overflow beyond W+1 bits is impossible.

## Timing
- Reset (`rst=1` at a rising edge) takes priority over everything. It forces IDLE, `Sum=0`, `Cout=0`, `busy=0`, `done=0`, `idx_q=0`, `carry_q=0`, and `part_q=0`.
- Reset mid-RUN or in DONE aborts the operation: no `done` pulse, and the previous result is cleared to 0.
- Let t0 be the edge where `start` is accepted. Then:
  - `busy=1` from t0 until edge t0+K.
  - Chunk i is registered at edge t0+i+1.
  - `Sum`/`Cout` are valid and `done=1` during the cycle between t0+K and t0+K+1.
  - `busy=0` in that DONE cycle.
- Latency from `start` to `done` is K cycles. Throughput is one operation per K+2 cycles; the earliest next accepted `start` is edge t0+K+2.
- `K=1`: `done` is asserted in the cycle after t0+1.
- `busy` and `done` are Moore outputs decoded from the state register; there are no combinational input-to-output paths.

## Test plan
With N=4, K=4 (W=16), the bench checks the same `Sum`/`Cout` against a behavioural `A+B+Cin` reference model every `done`:
- Reset: hold `rst=1` 2 cycles with `start=1` → `Sum=16'h0000`, `Cout=0`, `busy=0`, `done=0`, and no operation starts.
- Basic: A=16'h0001, B=16'h0002, Cin=0 → `Sum=16'h0003`, `Cout=0`; `done` pulses exactly once, 4 cycles after the `start` edge; `busy` is high for 4 cycles.
- Full carry ripple across chunks: A=16'hFFFF, B=16'h0001, Cin=0 → `Sum=16'h0000`, `Cout=1`. Also A=16'hA5A5, B=16'h5A5A, Cin=1 → `Sum=16'h0000`, `Cout=1`.
- Max overflow: A=16'hFFFF, B=16'hFFFF, Cin=1 → `Sum=16'hFFFF`, `Cout=1`.
- Ignored inputs: start A=16'h1234, B=16'h1111, Cin=0. Then, during RUN, change A/B/Cin and pulse `start` with A=16'h0F0F → one `done`, `Sum=16'h2345`, `Cout=0`. The previous result is held until `done`.
- Reset mid-op: assert `rst` 2 cycles after `start` → no `done`, `Sum=0`, `Cout=0`. A following A=16'h7FFF, B=16'h0001, Cin=0 → `Sum=16'h8000`, `Cout=0`.
